// File: rtl/ras_stack.sv
// ============================================================================
// Module   : ras_stack
// Brief    : Circular return address stack with saturating occupancy count
//            and a tos/cnt checkpoint for misprediction recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
  parameter int PTR_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ctl_vld_i,
  input  logic [1:0]       ras_ctl_i,
  input  logic [63:0]      push_pc_i,
  input  logic             restore_vld_i,
  input  logic [PTR_W-1:0] restore_tos_i,
  input  logic [PTR_W:0]   restore_cnt_i,
  output logic [63:0]      ras_data_o,
  output logic             ras_empty_o,
  output logic [PTR_W-1:0] ckpt_tos_o,
  output logic [PTR_W:0]   ckpt_cnt_o
);

  localparam int             c_DEPTH     = 2 ** PTR_W;
  localparam logic [PTR_W:0] c_DEPTH_CNT = (PTR_W + 1)'(c_DEPTH);

  localparam logic [1:0] c_OP_NONE     = 2'b00;
  localparam logic [1:0] c_OP_PUSH     = 2'b01;
  localparam logic [1:0] c_OP_POP      = 2'b10;
  localparam logic [1:0] c_OP_POP_PUSH = 2'b11;

  logic [63:0]      r_entry [c_DEPTH];
  logic [PTR_W-1:0] r_tos;
  logic [PTR_W:0]   r_cnt;

  logic [63:0]      w_ret;
  logic [PTR_W-1:0] w_tos_inc;
  logic [PTR_W-1:0] w_tos_dec;

  assign w_ret     = push_pc_i + 64'd4;
  assign w_tos_inc = r_tos + 1'b1;
  assign w_tos_dec = r_tos - 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tos <= '0;
      r_cnt <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else if (restore_vld_i) begin
      // Recovery wins over the ctl op of the same cycle; entries are kept.
      r_tos <= restore_tos_i;
      r_cnt <= restore_cnt_i;
    end else if (ctl_vld_i) begin
      case (ras_ctl_i)
        c_OP_PUSH: begin
          r_tos            <= w_tos_inc;
          r_entry[w_tos_inc] <= w_ret;
          if (r_cnt != c_DEPTH_CNT) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_OP_POP: begin
          r_tos <= w_tos_dec;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        c_OP_POP_PUSH: begin
          r_entry[r_tos] <= w_ret;
          if (r_cnt == '0) begin
            r_cnt <= (PTR_W + 1)'(1);
          end
        end
        c_OP_NONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign ras_data_o  = r_entry[r_tos];
  assign ras_empty_o = (r_cnt == '0);
  assign ckpt_tos_o  = r_tos;
  assign ckpt_cnt_o  = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ras_stack.sv
// ============================================================================
// Module   : tb_ras_stack
// Brief    : Table-driven bench for ras_stack with an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ras_stack;

  logic        clk;
  logic        rst_i;
  logic        ctl_vld_i;
  logic [1:0]  ras_ctl_i;
  logic [63:0] push_pc_i;
  logic        restore_vld_i;
  logic [2:0]  restore_tos_i;
  logic [3:0]  restore_cnt_i;
  logic [63:0] ras_data_o;
  logic        ras_empty_o;
  logic [2:0]  ckpt_tos_o;
  logic [3:0]  ckpt_cnt_o;

  ras_stack #(.PTR_W(3)) u_dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ctl_vld_i     (ctl_vld_i),
    .ras_ctl_i     (ras_ctl_i),
    .push_pc_i     (push_pc_i),
    .restore_vld_i (restore_vld_i),
    .restore_tos_i (restore_tos_i),
    .restore_cnt_i (restore_cnt_i),
    .ras_data_o    (ras_data_o),
    .ras_empty_o   (ras_empty_o),
    .ckpt_tos_o    (ckpt_tos_o),
    .ckpt_cnt_o    (ckpt_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [1:0]  ctl;
    logic [63:0] pc;
    logic        rv;
    logic [2:0]  rtos;
    logic [3:0]  rcnt;
    logic        pre;
    logic [63:0] pre_data;
    logic [63:0] data;
    logic [2:0]  tos;
    logic [3:0]  cnt;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [2:0]  tos;
    logic [3:0]  cnt;
    logic        empty;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Illegal restore count must never be driven by this bench.
  always @(negedge clk) begin
    if (restore_vld_i && !rst_i) begin
      assert (restore_cnt_i <= 4'd8)
        else $error("restore_cnt_i=%0d exceeds depth", restore_cnt_i);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [1:0] c, input logic [63:0] p,
                     input logic rv, input logic [2:0] rt, input logic [3:0] rc,
                     input logic pre, input logic [63:0] pd,
                     input logic [63:0] d, input logic [2:0] t, input logic [3:0] n);
    vec_t e;
    e.rst = r; e.vld = v; e.ctl = c; e.pc = p; e.rv = rv; e.rtos = rt; e.rcnt = rc;
    e.pre = pre; e.pre_data = pd; e.data = d; e.tos = t; e.cnt = n;
    vecs.push_back(e);
  endtask

  task automatic rst_v();
    add(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0);
  endtask
  task automatic push_v(input logic [63:0] p, input logic [63:0] d, input logic [2:0] t, input logic [3:0] n);
    add(0, 1, 2'b01, p, 0, 0, 0, 0, 0, d, t, n);
  endtask
  task automatic pop_v(input logic [63:0] pd, input logic [63:0] d, input logic [2:0] t, input logic [3:0] n);
    add(0, 1, 2'b10, 0, 0, 0, 0, 1, pd, d, t, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  v;
    exp_t  e;
    exp_t  g;

    // Reset then 10 idle cycles
    rst_v();
    for (int i = 0; i < 10; i++) add(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 64'h0, 0, 0);
    // Three pushes, three pops; pre_data is the target seen when each pop is presented
    push_v(64'h1000, 64'h1004, 1, 1);
    push_v(64'h2000, 64'h2004, 2, 2);
    push_v(64'h3000, 64'h3004, 3, 3);
    pop_v(64'h3004, 64'h2004, 2, 2);
    pop_v(64'h2004, 64'h1004, 1, 1);
    pop_v(64'h1004, 64'h0, 0, 0);
    // Overflow: 10 pushes of 0x100*k
    rst_v();
    for (int k = 1; k <= 10; k++)
      push_v(64'(k) * 64'h100, 64'(k) * 64'h100 + 64'd4, 3'(k % 8), 4'((k > 8) ? 8 : k));
    pop_v(64'hA04, 64'h904, 1, 7);
    pop_v(64'h904, 64'h804, 0, 6);
    pop_v(64'h804, 64'h704, 7, 5);
    pop_v(64'h704, 64'h604, 6, 4);
    pop_v(64'h604, 64'h504, 5, 3);
    pop_v(64'h504, 64'h404, 4, 2);
    pop_v(64'h404, 64'h304, 3, 1);
    pop_v(64'h304, 64'hA04, 2, 0);
    pop_v(64'hA04, 64'h904, 1, 0);
    // Pop+push over 0x2004, then from an empty stack
    rst_v();
    push_v(64'h2000, 64'h2004, 1, 1);
    add(0, 1, 2'b11, 64'h5000, 0, 0, 0, 1, 64'h2004, 64'h5004, 1, 1);
    rst_v();
    add(0, 1, 2'b11, 64'h9000, 0, 0, 0, 1, 64'h0, 64'h9004, 0, 1);
    // Restore priority over a same-cycle push
    rst_v();
    push_v(64'h1000, 64'h1004, 1, 1);
    push_v(64'h2000, 64'h2004, 2, 2);
    push_v(64'h7000, 64'h7004, 3, 3);
    pop_v(64'h7004, 64'h2004, 2, 2);
    pop_v(64'h2004, 64'h1004, 1, 1);
    add(0, 1, 2'b01, 64'h8000, 1, 2, 2, 0, 0, 64'h2004, 2, 2);
    add(0, 0, 2'b00, 0, 1, 3, 3, 0, 0, 64'h7004, 3, 3);
    // Return address wraps; invalid and none codes change nothing
    push_v(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 4, 4);
    add(0, 0, 2'b01, 64'hABC, 0, 0, 0, 0, 0, 64'h0, 4, 4);
    add(0, 1, 2'b00, 64'hABC, 0, 0, 0, 0, 0, 64'h0, 4, 4);
    // Reset beats push and restore, and clears the entries
    push_v(64'h4000, 64'h4004, 5, 5);
    add(1, 1, 2'b01, 64'h4000, 1, 5, 5, 0, 0, 64'h0, 0, 0);
    add(0, 0, 2'b00, 0, 1, 5, 5, 0, 0, 64'h0, 5, 5);

    rst_i = 1'b1; ctl_vld_i = 1'b0; ras_ctl_i = 2'b00; push_pc_i = '0;
    restore_vld_i = 1'b0; restore_tos_i = '0; restore_cnt_i = '0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      rst_i = v.rst; ctl_vld_i = v.vld; ras_ctl_i = v.ctl; push_pc_i = v.pc;
      restore_vld_i = v.rv; restore_tos_i = v.rtos; restore_cnt_i = v.rcnt;
      if (v.pre) chk($sformatf("v%0d pre_data", i), ras_data_o, v.pre_data);
      e.data = v.data; e.tos = v.tos; e.cnt = v.cnt; e.empty = (v.cnt == 4'd0);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      chk($sformatf("v%0d data", i),  ras_data_o,         g.data);
      chk($sformatf("v%0d tos", i),   64'(ckpt_tos_o),    64'(g.tos));
      chk($sformatf("v%0d cnt", i),   64'(ckpt_cnt_o),    64'(g.cnt));
      chk($sformatf("v%0d empty", i), 64'(ras_empty_o),   64'(g.empty));
    end

    @(negedge clk);
    rst_i = 1'b0; ctl_vld_i = 1'b0; restore_vld_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ras_stack.md
# ras_stack

Return address stack for fetch stage 1. It consumes the per-way `ras_ctl` codes from the branch decoders: 00 none, 01 push, 10 pop, 11 pop+push. It supplies the predicted return target to every decoder through `ras_data_o`. The stack is a circular buffer with a saturating occupancy count. A pointer checkpoint is exported so the backend can restore the stack on a misprediction.

## Interface
- `PTR_W`, default 3: pointer width; the stack holds DEPTH = 2**PTR_W entries (default 8).
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `ctl_vld_i`  in  1  qualifies `ras_ctl_i`; low means no action regardless of code.
- `ras_ctl_i`  in  2  00 none, 01 push, 10 pop, 11 pop+push; taken from the first predicted-taken way of the fetch block.
- `push_pc_i`  in  64  PC of the call instruction (fetch-1 PC of that way).
- `restore_vld_i`  in  1  misprediction recovery strobe.
- `restore_tos_i`  in  PTR_W  pointer value to restore.
- `restore_cnt_i`  in  PTR_W+1  count value to restore.
- `ras_data_o`  out  64  current top-of-stack entry; predicted return target.
- `ras_empty_o`  out  1  high when count == 0.
- `ckpt_tos_o`  out  PTR_W  current pointer, captured per branch by the backend.
- `ckpt_cnt_o`  out  PTR_W+1  current count, captured with `ckpt_tos_o`.

## Operation
- State:
  - `entry[0..DEPTH-1]`, 64 bits each.
  - `tos`, PTR_W bits; points at the top valid entry.
  - `cnt`, PTR_W+1 bits.
- Outputs:
  - `ras_data_o` = `entry[tos]`, read combinationally from registered state, with no bypass of same-cycle updates.
  - `ckpt_*` equal `tos`/`cnt`.
- Return address: ret = `push_pc_i` + 64'd4, modulo 2^64 (wraps at all-ones).
- Push (01): `tos` ← `tos`+1 mod DEPTH; `entry[tos+1]` ← ret; `cnt` ← min(`cnt`+1, DEPTH).
  - On overflow the oldest entry is silently overwritten.
- Pop (10): `tos` ← `tos`−1 mod DEPTH; `cnt` ← max(`cnt`−1, 0).
  - Popping an empty stack still moves `tos`, and the stale data is accepted as the prediction.
  - Entries are not cleared on pop.
- Pop+push (11): `entry[tos]` ← ret; `tos` unchanged.
  - `cnt` unchanged, except `cnt` = 0 becomes 1.
  - This cycle's `ras_data_o` shows the old top, which the decoder uses as the target.
- None (00), or `ctl_vld_i` low: no state change.
- Restore: `tos` ← `restore_tos_i`, `cnt` ← `restore_cnt_i`.
  - Entry contents are untouched.
  - Restore has priority over a same-cycle ctl operation; that ctl operation is dropped.
- `restore_cnt_i` > DEPTH is illegal and is flagged by a bench assertion; RTL behaviour is then undefined.

## Timing
- Reset (synchronous, `rst_i` high at the edge):
  - `tos` = 0, `cnt` = 0, all entries = 0.
  - Hence `ras_data_o` = 0, `ras_empty_o` = 1, `ckpt_tos_o` = 0, `ckpt_cnt_o` = 0 from the first cycle after reset.
- Reset overrides restore and ctl in the same cycle.
- Reset asserted mid-sequence discards all entries.
- Latency:
  - An operation at edge N is visible on all outputs in cycle N+1.
  - Push then an immediate pop in the next cycle returns the pushed ret.
- One operation per cycle; there is no backpressure and no stall input. The fetch unit gates `ctl_vld_i` during stalls.
- Pointer wrap: `tos` = DEPTH−1 plus push gives 0; `tos` = 0 plus pop gives DEPTH−1.

## Test plan
- Reset, then idle: `ras_data_o` = 0, `ras_empty_o` = 1, `ckpt_tos_o` = 0; the count stays 0 for 10 cycles.
- Push with `push_pc_i` = 0x1000, 0x2000, 0x3000 on consecutive cycles, then three pops:
  - `ras_data_o` reads 0x3004, 0x2004, 0x1004 on the cycles the pops are presented.
  - Final `cnt` = 0 and `tos` = 0.
- Overflow: 10 pushes with PCs 0x100·k for k = 1..10.
  - `cnt` saturates at 8 and `tos` = 2.
  - 8 pops yield 0xA04 down to 0x304.
  - A 9th pop keeps `cnt` at 0 and returns stale 0xA04 (entry 2 after wrap).
- Pop+push: stack holds 0x2004. Op 11 with `push_pc_i` = 0x5000.
  - Same-cycle `ras_data_o` = 0x2004.
  - Next cycle `ras_data_o` = 0x5004; `tos` and `cnt` unchanged.
  - From an empty stack, op 11 makes `cnt` 1.
- Restore: checkpoint `tos`/`cnt` (2, 2). Push 0x7000 and pop twice. Then assert restore with (2, 2) in the same cycle as a push.
  - The push is ignored.
  - `tos` = 2, `cnt` = 2, and `ras_data_o` equals the entry[2] value present before the checkpoint, unless a later push overwrote it.
- Wrap of ret: `push_pc_i` = 0xFFFF_FFFF_FFFF_FFFC gives `ras_data_o` = 0 next cycle.
- Reset asserted together with a push leaves the stack empty.
